// File: rtl/midi_pkg.sv
// Shared constants, state encodings and helpers for the MIDI UART front end.
package midi_pkg;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  localparam int DEF_CLK_HZ = 25_000_000;
  localparam int DEF_BAUD   = 31_250;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic int bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Data bytes following a status byte; 0 means unbounded (sysex).
  function automatic logic [1:0] data_len(input logic [7:0] status);
    case (status[7:4])
      4'hC, 4'hD: return 2'd1;
      4'hF:       return 2'd0;
      default:    return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/midi_tx_serializer.sv
// MIDI byte serializer: start bit, 8 data bits LSB-first, stop bit, BIT_CYC clocks each.
module midi_tx_serializer
  import midi_pkg::*;
#(
  parameter int BIT_CYC = 800
) (
  input  logic       CLOCK_25,
  input  logic       reset_reg_N,
  input  logic       send_byte,
  input  logic [7:0] out_data,
  output logic       txd,
  output logic       out_ready
);

  localparam int CNT_W = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] BIT_M1 = CNT_W'(BIT_CYC - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Requests outside TX_IDLE are never looked at, so a busy transmitter drops them.
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state     <= TX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      txd       <= 1'b1;
      out_ready <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (send_byte) begin
            shift     <= out_data;
            txd       <= 1'b0;
            out_ready <= 1'b0;
            cnt       <= BIT_M1;
            state     <= TX_START;
          end
        end
        TX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            txd     <= shift[0];
            cnt     <= BIT_M1;
            bit_idx <= '0;
            state   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= BIT_M1;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end
        end
        TX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_ready <= 1'b1;
            state     <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_uart_port.sv
// MIDI front end: RX deserializer, running-status parser with byteready stretcher,
// and the sysex-dump transmitter.
module midi_uart_port
  import midi_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int BAUD          = DEF_BAUD,
  parameter int BYTEREADY_CYC = 8
) (
  input  logic       CLOCK_25,
  input  logic       reset_reg_N,
  input  logic       midi_rxd,
  output logic       midi_txd,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midibyte,
  input  logic       midi_send_byte,
  input  logic [7:0] midi_out_data,
  output logic       midi_out_ready,
  output logic       rx_frame_err
);

  localparam int BIT_CYC = bit_cyc(CLK_HZ, BAUD);
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYC / 2 - 1);
  localparam int BR_W = $clog2(BYTEREADY_CYC + 1);
  localparam logic [BR_W-1:0] BR_M1 = BR_W'(BYTEREADY_CYC - 1);

  rx_state_t        rx_state;
  logic [1:0]       rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_valid;
  logic             rxd_s;

  assign rxd_s = rx_sync[1];

  // NOTE: every register here updates with <=, so all branches read the pre-edge
  // values; a blocking = would let later statements see half-updated state.
  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      rx_sync      <= 2'b11;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[0], midi_rxd};
      rx_prev      <= rxd_s;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rxd_s && rx_prev) begin
            rx_cnt   <= HALF_M1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else if (rxd_s) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt   <= BIT_M1;
            rx_bit   <= '0;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_shift <= {rxd_s, rx_shift[7:1]};
            rx_cnt   <= BIT_M1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else if (rxd_s) begin
            rx_valid <= 1'b1;
            rx_state <= RX_IDLE;
          end else begin
            rx_frame_err <= 1'b1;
            rx_state     <= RX_WAITHI;
          end
        end
        RX_WAITHI: if (rxd_s) rx_state <= RX_IDLE;
        default:   rx_state <= RX_IDLE;
      endcase
    end
  end

  logic            rs_valid;
  logic            deliver;
  logic            nxt_rs;
  logic [7:0]      nxt_status;
  logic [7:0]      nxt_nr;
  logic [7:0]      nr_inc;
  logic [BR_W-1:0] br_cnt;

  assign nr_inc = (midibyte_nr == 8'hFF) ? midibyte_nr : midibyte_nr + 8'd1;

  // rx_shift holds the completed byte for the cycle rx_valid is high.
  always_comb begin
    deliver    = 1'b0;
    nxt_rs     = rs_valid;
    nxt_status = cur_status;
    nxt_nr     = midibyte_nr;
    if (rx_valid && rx_shift < RT_MIN) begin
      if (rx_shift[7] && (rx_shift < ST_SYSEX || rx_shift == ST_SYSEX)) begin
        deliver    = 1'b1;
        nxt_status = rx_shift;
        nxt_nr     = 8'd0;
        nxt_rs     = 1'b1;
      end else if (rx_shift == ST_EOX) begin
        if (cur_status == ST_SYSEX) begin
          deliver = 1'b1;
          nxt_nr  = nr_inc;
          nxt_rs  = 1'b0;
        end
      end else if (rx_shift[7]) begin
        nxt_rs = 1'b0;
      end else if (rs_valid) begin
        deliver = 1'b1;
        case (data_len(cur_status))
          2'd2:    nxt_nr = (midibyte_nr == 8'd1) ? 8'd2 : 8'd1;
          2'd1:    nxt_nr = 8'd1;
          default: nxt_nr = nr_inc;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      rs_valid    <= 1'b0;
      cur_status  <= 8'h00;
      midibyte_nr <= 8'd0;
      midibyte    <= 8'd0;
      byteready   <= 1'b0;
      br_cnt      <= '0;
    end else begin
      rs_valid <= nxt_rs;
      if (deliver) begin
        cur_status  <= nxt_status;
        midibyte_nr <= nxt_nr;
        midibyte    <= rx_shift;
        byteready   <= 1'b1;
        br_cnt      <= BR_M1;
      end else if (br_cnt != '0) begin
        br_cnt <= br_cnt - 1'b1;
      end else begin
        byteready <= 1'b0;
      end
    end
  end

  midi_tx_serializer #(.BIT_CYC(BIT_CYC)) u_tx (
    .CLOCK_25    (CLOCK_25),
    .reset_reg_N (reset_reg_N),
    .send_byte   (midi_send_byte),
    .out_data    (midi_out_data),
    .txd         (midi_txd),
    .out_ready   (midi_out_ready)
  );

endmodule
